carregador_matrizes: RTL and testbench

Serial-to-parallel operand loader placed directly upstream of the combinational N×N signed matrix multiplier. It accepts matrix elements one at a time over a valid/ready handshake, first all of A and then all of B, each in row-major order. It assembles them into the flat `A`/`B` buses the multiplier consumes. When both matrices are complete it holds them stable and raises `prontas` until the consumer releases it with `liberar`.

---
 rtl/carregador_matrizes.sv | 111 +++++++++++
 tb/tb_carregador_matrizes.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/carregador_matrizes.sv
// -----------------------------------------------------------------------------
// carregador_matrizes
//
// Serial-to-parallel operand loader for the combinational N x N signed matrix
// multiplier. Elements arrive one per transfer over a valid/ready handshake:
// first all of A, then all of B, each in row-major order. When both matrices
// are complete they are held stable and 'prontas' stays high until the
// consumer releases them with 'liberar'.
//
// Parameters
//   N      matrix dimension (each matrix holds N*N elements)
//   WIDTH  bits per signed element
//
// Ports
//   clk           single clock, rising edge
//   rst           synchronous reset, active-high (priority over abortar)
//   in_valid      in_data holds an element
//   in_ready      loader can accept an element this cycle
//   in_data       signed element, stored verbatim
//   abortar       discard any partial load, clear A/B, restart at A[0]
//   liberar       consumer took the operands; rearm (only honoured in PRONTO)
//   A, B          flat matrices; element idx=i*N+k at [idx*WIDTH +: WIDTH]
//   prontas       A and B complete and stable
//   indice        index of the next element expected
//   carregando_b  0 while loading A, 1 while loading B
// -----------------------------------------------------------------------------
module carregador_matrizes #(
    parameter  int N     = 3,
    parameter  int WIDTH = 8,
    localparam int NE    = N * N,
    localparam int IW    = (NE > 1) ? $clog2(NE) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    input  logic                  abortar,
    input  logic                  liberar,
    output logic [NE*WIDTH-1:0]   A,
    output logic [NE*WIDTH-1:0]   B,
    output logic                  prontas,
    output logic [IW-1:0]         indice,
    output logic                  carregando_b
);

    localparam logic [1:0] CARREGA_A = 2'd0;
    localparam logic [1:0] CARREGA_B = 2'd1;
    localparam logic [1:0] PRONTO    = 2'd2;

    localparam logic [IW-1:0] ULTIMO = IW'(NE - 1);

    logic [1:0] estado;

    // Status outputs are pure decodes of the registered state, so no input
    // ever reaches an output combinationally.
    assign in_ready     = (estado == CARREGA_A) || (estado == CARREGA_B);
    assign carregando_b = (estado == CARREGA_B);
    assign prontas      = (estado == PRONTO);

    // NOTE: all state here is written with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        // NOTE: A and B are wide operand registers, not a RAM; they are reset
        // because both rst and abortar must leave them architecturally zero.
        if (rst || abortar) begin
            estado <= CARREGA_A;
            indice <= '0;
            A      <= '0;
            B      <= '0;
        end else begin
            case (estado)
                CARREGA_A: begin
                    if (in_valid) begin
                        A[indice*WIDTH +: WIDTH] <= in_data;
                        if (indice == ULTIMO) begin
                            indice <= '0;
                            estado <= CARREGA_B;
                        end else begin
                            indice <= indice + IW'(1);
                        end
                    end
                end
                CARREGA_B: begin
                    if (in_valid) begin
                        B[indice*WIDTH +: WIDTH] <= in_data;
                        if (indice == ULTIMO) begin
                            indice <= '0;
                            estado <= PRONTO;
                        end else begin
                            indice <= indice + IW'(1);
                        end
                    end
                end
                PRONTO: begin
                    // Operands stay frozen; old contents remain visible until
                    // the next load overwrites them element by element.
                    if (liberar) begin
                        estado <= CARREGA_A;
                        indice <= '0;
                    end
                end
                default: begin
                    estado <= CARREGA_A;
                    indice <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_carregador_matrizes.sv
// -----------------------------------------------------------------------------
// tb_carregador_matrizes
//
// Directed self-checking bench for carregador_matrizes with N=3, WIDTH=8.
// Inputs change 1 time unit after each rising edge; outputs are sampled at
// the same point, i.e. after the edge under test has settled.
// -----------------------------------------------------------------------------
module tb_carregador_matrizes;

    localparam int N  = 3;
    localparam int W  = 8;
    localparam int NE = N * N;
    localparam int IW = $clog2(NE);

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [W-1:0]      in_data;
    logic              abortar;
    logic              liberar;
    logic [NE*W-1:0]   A;
    logic [NE*W-1:0]   B;
    logic              prontas;
    logic [IW-1:0]     indice;
    logic              carregando_b;

    int n_checks = 0;
    int n_pass   = 0;

    carregador_matrizes #(.N(N), .WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .abortar      (abortar),
        .liberar      (liberar),
        .A            (A),
        .B            (B),
        .prontas      (prontas),
        .indice       (indice),
        .carregando_b (carregando_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected packed matrices, built by the bench from element lists.
    function automatic logic [71:0] pack(input logic [7:0] e [9]);
        logic [71:0] r;
        r = '0;
        for (int i = 0; i < 9; i++) r[i*8 +: 8] = e[i];
        return r;
    endfunction

    task automatic check_reset_state(input string tag);
        check({tag, ".prontas"},  72'(prontas),      72'd0);
        check({tag, ".in_ready"}, 72'(in_ready),     72'd1);
        check({tag, ".carr_b"},   72'(carregando_b), 72'd0);
        check({tag, ".indice"},   72'(indice),       72'd0);
        check({tag, ".A"},        72'(A),            72'd0);
        check({tag, ".B"},        72'(B),            72'd0);
    endtask

    logic [7:0]  seq_a [9];
    logic [7:0]  ident [9];
    logic [7:0]  rev   [9];
    logic [7:0]  sgn   [9];
    logic [71:0] exp_a;
    logic [71:0] exp_b;

    initial begin
        seq_a = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
        ident = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1};
        rev   = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        sgn   = '{8'h80, 8'h7F, 8'hFF, 8'h00, 8'h01, 8'hFE, 8'h40, 8'hC0, 8'h05};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; abortar = 1'b0; liberar = 1'b0;
        step(); step();
        rst = 1'b0;
        check_reset_state("reset");

        // ---------------- Full back-to-back load ----------------
        for (int c = 0; c < 18; c++) begin
            in_valid = 1'b1;
            in_data  = (c < 9) ? seq_a[c] : ident[c-9];
            step();
            if (c == 7)  check("full.carr_b_before", 72'(carregando_b), 72'd0);
            if (c == 8)  check("full.carr_b_rise",   72'(carregando_b), 72'd1);
            if (c == 16) check("full.prontas_17",    72'(prontas),      72'd0);
        end
        check("full.prontas_18", 72'(prontas),  72'd1);
        check("full.in_ready",   72'(in_ready), 72'd0);
        check("full.A", 72'(A), 72'h090807060504030201);
        check("full.B", 72'(B), 72'h010000000100000001);
        // 19th element offered while PRONTO must not be consumed.
        in_data = 8'h55;
        step();
        in_valid = 1'b0;
        check("full.19th_A",    72'(A),       72'h090807060504030201);
        check("full.19th_B",    72'(B),       72'h010000000100000001);
        check("full.19th_pr",   72'(prontas), 72'd1);
        check("full.19th_idx",  72'(indice),  72'd0);

        // ---------------- Release and reload ----------------
        liberar = 1'b1;
        step();
        liberar = 1'b0;
        check("rel.prontas",  72'(prontas),  72'd0);
        check("rel.in_ready", 72'(in_ready), 72'd1);
        check("rel.A_kept",   72'(A),        72'h090807060504030201);
        check("rel.B_kept",   72'(B),        72'h010000000100000001);
        exp_a = 72'h090807060504030201;
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1;
            in_data  = rev[i];
            liberar  = (i == 3);        // mid-load liberar must be ignored
            step();
            exp_a[i*8 +: 8] = rev[i];
            check($sformatf("rel.A_elem%0d", i), 72'(A), exp_a);
        end
        in_valid = 1'b0; liberar = 1'b0;
        check("rel.A_final",  72'(A),            pack(rev));
        check("rel.carr_b",   72'(carregando_b), 72'd1);
        check("rel.idx",      72'(indice),       72'd0);

        // ---------------- Abort ----------------
        abortar = 1'b1;
        step();
        abortar = 1'b0;
        check_reset_state("abort0");
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = seq_a[i];
            step();
        end
        check("abort.idx5", 72'(indice), 72'd5);
        in_data = 8'h77; abortar = 1'b1;   // concurrent element is dropped
        step();
        abortar = 1'b0; in_valid = 1'b0;
        check_reset_state("abort");
        // Full reload after abort.
        for (int c = 0; c < 18; c++) begin
            in_valid = 1'b1;
            in_data  = (c < 9) ? seq_a[c] : ident[c-9];
            step();
        end
        in_valid = 1'b0;
        check("abort.reload_pr", 72'(prontas), 72'd1);
        check("abort.reload_A",  72'(A),       pack(seq_a));
        check("abort.reload_B",  72'(B),       pack(ident));

        // ---------------- Gapped valid ----------------
        abortar = 1'b1;
        step();
        abortar = 1'b0;
        for (int c = 0; c < 36; c++) begin
            in_valid = c[0];
            in_data  = c[0] ? ((c < 18) ? seq_a[c/2] : ident[c/2-9]) : 8'hAA;
            step();
            if (c == 4 || c == 22) check($sformatf("gap.idx_hold%0d", c), 72'(indice), 72'((c / 2) % 9));
            if (c == 34) check("gap.prontas_35", 72'(prontas), 72'd0);
        end
        in_valid = 1'b0;
        check("gap.prontas_36", 72'(prontas), 72'd1);
        check("gap.A", 72'(A), 72'h090807060504030201);
        check("gap.B", 72'(B), 72'h010000000100000001);

        // ---------------- Signed / boundary values ----------------
        liberar = 1'b1;
        step();
        liberar = 1'b0;
        for (int c = 0; c < 18; c++) begin
            in_valid = 1'b1;
            in_data  = (c < 9) ? sgn[c] : 8'h80;
            step();
            if (c == 7) check("sgn.carr_b_before", 72'(carregando_b), 72'd0);
            if (c == 8) check("sgn.carr_b_rise",   72'(carregando_b), 72'd1);
        end
        in_valid = 1'b0;
        check("sgn.a0", 72'(A[0  +: 8]), 72'h80);
        check("sgn.a1", 72'(A[8  +: 8]), 72'h7F);
        check("sgn.a2", 72'(A[16 +: 8]), 72'hFF);
        check("sgn.A",  72'(A), pack(sgn));
        exp_b = {9{8'h80}};
        check("sgn.B",  72'(B), exp_b);
        check("sgn.pr", 72'(prontas), 72'd1);

        // ---------------- Reset mid-load ----------------
        liberar = 1'b1;
        step();
        liberar = 1'b0;
        for (int c = 0; c < 13; c++) begin
            in_valid = 1'b1;
            in_data  = seq_a[c % 9];
            step();
        end
        check("rstmid.carr_b", 72'(carregando_b), 72'd1);
        check("rstmid.idx",    72'(indice),       72'd4);
        rst = 1'b1;
        step();
        rst = 1'b0; in_valid = 1'b0;
        check_reset_state("rstmid");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
